hidden_state_buffer: RTL and testbench

Collects the 8-lane float32 tanh result vector h_t, one vector per `in_valid` cycle, into a DEPTH-entry vector FIFO. It tags each entry with its timestep index and presents it with a valid/ready handshake to the next timestep's matrix-vector stage. It sits directly downstream of the 1x8 tanh stage. That stage has no backpressure, so this block absorbs bursts, reports drops, and optionally scrubs NaNs.

---
 rtl/rnn_pkg.sv | 15 +
 rtl/hidden_state_buffer_if.sv | 29 ++
 rtl/hidden_state_buffer_nan_scrub.sv | 21 ++
 rtl/hidden_state_buffer.sv | 110 +++++++++++
 tb/tb_hidden_state_buffer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/rnn_pkg.sv
// Shared RNN datapath types and float32 helpers.
package rnn_pkg;

    typedef logic [31:0] float32_t;

    localparam int       LANES_DEFAULT = 8;
    localparam logic [7:0] FP_EXP_ALL1 = 8'hFF;
    localparam float32_t FP_QNAN       = 32'h7FC0_0000;

    // NaN: all-ones exponent with a non-zero mantissa; +/-Inf is not a NaN.
    function automatic logic fp_is_nan(input float32_t v);
        return (v[30:23] == FP_EXP_ALL1) && (v[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/hidden_state_buffer_if.sv
// Producer/consumer signals of the hidden-state vector FIFO.
interface hidden_state_buffer_if #(
    parameter int LANES   = rnn_pkg::LANES_DEFAULT,
    parameter int SEQ_LEN = 16,
    parameter int DEPTH   = 4
);
    logic                           clr;
    logic                           in_valid;
    logic [LANES-1:0][31:0]         in_data;
    logic                           in_ready;
    logic                           out_valid;
    logic                           out_ready;
    logic [LANES-1:0][31:0]         out_data;
    logic [$clog2(SEQ_LEN)-1:0]     out_t;
    logic                           out_last;
    logic [$clog2(DEPTH+1)-1:0]     count;
    logic                           overflow;
    logic                           nan_flag;

    modport slave (
        input  clr, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_t, out_last, count, overflow, nan_flag
    );

    modport master (
        output clr, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_t, out_last, count, overflow, nan_flag
    );
endinterface

// File: rtl/hidden_state_buffer_nan_scrub.sv
// Per-vector NaN detect/replace; compiled only when HSB_NAN_CHECK_EN is defined.
`ifdef HSB_NAN_CHECK_EN
module hsb_nan_scrub
    import rnn_pkg::*;
#(
    parameter int LANES = LANES_DEFAULT
) (
    input  float32_t [LANES-1:0] in_data,
    output float32_t [LANES-1:0] out_data,
    output logic                 nan_any
);
    logic [LANES-1:0] is_nan;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign is_nan[i]   = fp_is_nan(in_data[i]);
        assign out_data[i] = is_nan[i] ? 32'h0000_0000 : in_data[i];
    end

    assign nan_any = |is_nan;
endmodule
`endif

// File: rtl/hidden_state_buffer.sv
// Timestep-tagged vector FIFO between the tanh stage and the next mat-vec stage.
// Optional NaN scrubbing of accepted vectors under HSB_NAN_CHECK_EN.
module hidden_state_buffer
    import rnn_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int SEQ_LEN = 16,
    parameter int LANES   = LANES_DEFAULT
) (
    input logic                  clk,
    input logic                  rst_n,
    hidden_state_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(SEQ_LEN);
    localparam int CW = $clog2(DEPTH+1);

    typedef float32_t [LANES-1:0] vec_t;

    vec_t          mem     [DEPTH];
    logic [TW-1:0] tag_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic [TW-1:0] wr_t;
    logic          ovf_q;
    logic          full, valid, pop, push_ok, nan_any;
    vec_t          wr_data;

    assign valid   = cnt != '0;
    assign full    = cnt == CW'(DEPTH);
    assign pop     = valid && bus.out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign push_ok = bus.in_valid && (!full || pop);

`ifdef HSB_NAN_CHECK_EN
    logic nan_q;

    hsb_nan_scrub #(.LANES(LANES)) u_scrub (
        .in_data  (bus.in_data),
        .out_data (wr_data),
        .nan_any  (nan_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nan_q <= 1'b0;
        else if (bus.clr)
            nan_q <= 1'b0;
        else if (push_ok && nan_any)
            nan_q <= 1'b1;
    end

    assign bus.nan_flag = nan_q;
`else
    assign wr_data      = bus.in_data;
    assign nan_any      = 1'b0;
    assign bus.nan_flag = nan_any;
`endif

    // Storage is reset so out_t reads 0 out of reset; clr leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i]     <= '0;
                tag_mem[i] <= '0;
            end
        end else if (push_ok && !bus.clr) begin
            mem[wr_ptr]     <= wr_data;
            tag_mem[wr_ptr] <= wr_t;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            wr_t   <= '0;
            ovf_q  <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            wr_t   <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
                wr_t   <= (wr_t == TW'(SEQ_LEN-1)) ? '0 : wr_t + TW'(1);
            end else if (bus.in_valid) begin
                ovf_q  <= 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = valid;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.out_t     = tag_mem[rd_ptr];
    assign bus.out_last  = valid && (tag_mem[rd_ptr] == TW'(SEQ_LEN-1));
    assign bus.count     = cnt;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_hidden_state_buffer.sv
// Directed scoreboard bench for hidden_state_buffer (DEPTH=4, SEQ_LEN=16, LANES=8).
module tb_hidden_state_buffer;
    localparam int DEPTH   = 4;
    localparam int SEQ_LEN = 16;
    localparam int LANES   = 8;

    typedef logic [LANES-1:0][31:0] vec_t;
    typedef struct {
        vec_t       d;
        logic [3:0] t;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;

    hidden_state_buffer_if #(.LANES(LANES), .SEQ_LEN(SEQ_LEN), .DEPTH(DEPTH)) bus ();

    hidden_state_buffer #(.DEPTH(DEPTH), .SEQ_LEN(SEQ_LEN), .LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    ent_t sb[$];
    int   wt    = 0;
    logic m_ovf = 1'b0;
    logic m_nan = 1'b0;
    int   nlast = 0;
    int   last_t = -1;

`ifdef HSB_NAN_CHECK_EN
    localparam bit SCRUB = 1'b1;
`else
    localparam bit SCRUB = 1'b0;
`endif

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t splat(input logic [31:0] v);
        vec_t r;
        for (int i = 0; i < LANES; i++) r[i] = v;
        return r;
    endfunction

    function automatic vec_t mk(input int k);
        vec_t r;
        for (int i = 0; i < LANES; i++) r[i] = 32'h4000_0000 + 32'(k * 256 + i);
        return r;
    endfunction

    // One clock: drive, check live outputs against the model, then advance the model.
    task automatic cyc(input logic iv, input vec_t d, input logic ordy, input logic c);
        logic pop, acc, hasnan;
        vec_t sd;
        ent_t e;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.clr       = c;
        #3;
        chk("out_valid", bus.out_valid, sb.size() != 0);
        chk("count", bus.count, sb.size());
        chk("in_ready", bus.in_ready, sb.size() != DEPTH);
        chk("overflow", bus.overflow, m_ovf);
        chk("nan_flag", bus.nan_flag, m_nan);
        pop = ordy && (sb.size() != 0);
        acc = iv && ((sb.size() < DEPTH) || pop);
        if (pop) begin
            chk("sb_data", bus.out_data, sb[0].d);
            chk("sb_tag", bus.out_t, sb[0].t);
            chk("sb_last", bus.out_last, sb[0].t == 4'(SEQ_LEN-1));
            if (bus.out_last) nlast++;
            last_t = int'(sb[0].t);
            void'(sb.pop_front());
        end
        if (c) begin
            sb.delete();
            wt = 0; m_ovf = 1'b0; m_nan = 1'b0;
        end else if (acc) begin
            sd = d; hasnan = 1'b0;
            for (int i = 0; i < LANES; i++)
                if (SCRUB && d[i][30:23] == 8'hFF && d[i][22:0] != 23'd0) begin
                    sd[i] = 32'h0; hasnan = 1'b1;
                end
            e.d = sd; e.t = 4'(wt);
            sb.push_back(e);
            wt = (wt + 1) % SEQ_LEN;
            m_nan = m_nan | hasnan;
        end else if (iv) begin
            m_ovf = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_count", bus.count, 0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_overflow", bus.overflow, 1'b0);
        chk("rst_nan_flag", bus.nan_flag, 1'b0);
        chk("rst_out_t", bus.out_t, 0);
        chk("rst_out_last", bus.out_last, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single vector
        cyc(1'b1, splat(32'h3F00_0000), 1'b0, 1'b0);
        chk("single_valid", bus.out_valid, 1'b1);
        chk("single_data", bus.out_data, splat(32'h3F00_0000));
        chk("single_t", bus.out_t, 0);
        chk("single_count", bus.count, 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("single_empty", bus.count, 0);

        // fill / overflow
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) cyc(1'b1, mk(k), 1'b0, 1'b0);
        chk("fill_count", bus.count, 4);
        chk("fill_in_ready", bus.in_ready, 1'b0);
        chk("fill_overflow", bus.overflow, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("fill_tag", bus.out_t, k);
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        chk("fill_no_fifth", bus.out_valid, 1'b0);

        // full push+pop
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) cyc(1'b1, mk(20 + k), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, mk(30 + k), 1'b1, 1'b0);
        chk("pp_count", bus.count, 4);
        chk("pp_overflow", bus.overflow, 1'b0);
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("pp_drained", bus.count, 0);

        // tag wrap
        cyc(1'b0, '0, 1'b0, 1'b1);
        nlast = 0;
        for (int k = 0; k < 17; k++) cyc(1'b1, mk(40 + k), 1'b1, 1'b0);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("wrap_nlast", nlast, 1);
        chk("wrap_17th_t", last_t, 0);

        // clr mid-stream with a concurrent push
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) cyc(1'b1, mk(60 + k), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("clr_pre_count", bus.count, 3);
        cyc(1'b1, mk(99), 1'b0, 1'b1);
        chk("clr_count", bus.count, 0);
        chk("clr_valid", bus.out_valid, 1'b0);
        chk("clr_overflow", bus.overflow, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // NaN scrub on an accepted push
        v = splat(32'h3F00_0000);
        v[3] = 32'h7FC0_0001;
        v[5] = 32'h7F80_0000;
        cyc(1'b1, v, 1'b0, 1'b0);
        chk("nan_lane3", bus.out_data[3], SCRUB ? 32'h0 : 32'h7FC0_0001);
        chk("nan_lane5", bus.out_data[5], 32'h7F80_0000);
        chk("nan_lane0", bus.out_data[0], 32'h3F00_0000);
        chk("nan_flag_set", bus.nan_flag, SCRUB);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // NaN on a dropped push leaves nan_flag alone
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) cyc(1'b1, mk(70 + k), 1'b0, 1'b0);
        cyc(1'b1, v, 1'b0, 1'b0);
        chk("drop_nan_flag", bus.nan_flag, 1'b0);
        chk("drop_overflow", bus.overflow, 1'b1);
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);

        // asynchronous reset mid-operation
        cyc(1'b1, mk(80), 1'b0, 1'b0);
        cyc(1'b1, mk(81), 1'b0, 1'b0);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", bus.count, 0);
        chk("arst_valid", bus.out_valid, 1'b0);
        chk("arst_out_t", bus.out_t, 0);
        sb.delete(); wt = 0; m_ovf = 1'b0; m_nan = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(1'b1, mk(90), 1'b0, 1'b0);
        chk("arst_tag_restart", bus.out_t, 0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
